// File: rtl/pwm_fade_ctrl.sv
// LED-style PWM fade sequencer: ramps duty between two plateaus,
// updating only on PWM period boundaries, looping until stopped.
module pwm_fade_ctrl #(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         period_tick,
  input  logic         start,
  input  logic         stop,
  input  logic [R-1:0] min_duty,
  input  logic [R-1:0] max_duty,
  input  logic [R-1:0] step,
  input  logic [7:0]   periods_per_step,
  input  logic [7:0]   hold_periods,
  output logic [R-1:0] duty,
  output logic         busy,
  output logic [2:0]   phase,
  output logic         cycle_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RAMP_UP   = 3'd2,
    HOLD_HIGH = 3'd3,
    RAMP_DOWN = 3'd4,
    HOLD_LOW  = 3'd5
  } state_t;

  state_t       state;
  logic [R-1:0] min_r;
  logic [R-1:0] max_r;
  logic [R-1:0] step_r;
  logic [7:0]   pps_r;
  logic [7:0]   hold_r;
  logic [7:0]   step_cnt;
  logic [7:0]   hold_cnt;
  logic         stop_pending;

  logic [R:0]          up_sum;
  logic signed [R+1:0] dn_diff;
  logic                up_sat;
  logic                dn_sat;
  logic                step_due;
  logic                hold_done;
  logic                abort;

  // Extra headroom bits make saturation exact instead of wrapping.
  assign up_sum    = {1'b0, duty} + {1'b0, step_r};
  assign dn_diff   = $signed({2'b00, duty}) - $signed({2'b00, step_r});
  assign up_sat    = up_sum >= {1'b0, max_r};
  assign dn_sat    = dn_diff <= $signed({2'b00, min_r});
  assign step_due  = step_cnt == (pps_r - 8'd1);
  assign hold_done = hold_cnt == hold_r;
  assign abort     = (state != IDLE) && (stop || stop_pending);

  assign busy  = state != IDLE;
  assign phase = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      duty         <= '0;
      cycle_done   <= 1'b0;
      min_r        <= '0;
      max_r        <= '0;
      step_r       <= '0;
      pps_r        <= '0;
      hold_r       <= '0;
      step_cnt     <= '0;
      hold_cnt     <= '0;
      stop_pending <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (state != IDLE && stop)
        stop_pending <= 1'b1;
      if (state == IDLE) begin
        stop_pending <= 1'b0;
        if (start && !stop) begin
          min_r  <= min_duty;
          max_r  <= max_duty;
          step_r <= (step == '0) ? {{(R-1){1'b0}}, 1'b1} : step;
          pps_r  <= (periods_per_step == 8'd0) ? 8'd1 : periods_per_step;
          hold_r <= hold_periods;
          state  <= LOAD;
        end
      end else if (period_tick) begin
        if (abort) begin
          duty         <= '0;
          step_cnt     <= '0;
          hold_cnt     <= '0;
          stop_pending <= 1'b0;
          state        <= IDLE;
        end else begin
          unique case (state)
            LOAD: begin
              duty     <= min_r;
              step_cnt <= '0;
              state    <= RAMP_UP;
            end
            RAMP_UP: begin
              if (step_due) begin
                step_cnt <= '0;
                if (up_sat) begin
                  duty     <= max_r;
                  hold_cnt <= '0;
                  state    <= HOLD_HIGH;
                end else begin
                  duty <= up_sum[R-1:0];
                end
              end else begin
                step_cnt <= step_cnt + 8'd1;
              end
            end
            HOLD_HIGH: begin
              if (hold_done) begin
                step_cnt <= '0;
                state    <= RAMP_DOWN;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
            RAMP_DOWN: begin
              if (step_due) begin
                step_cnt <= '0;
                if (dn_sat) begin
                  duty     <= min_r;
                  hold_cnt <= '0;
                  state    <= HOLD_LOW;
                end else begin
                  duty <= dn_diff[R-1:0];
                end
              end else begin
                step_cnt <= step_cnt + 8'd1;
              end
            end
            HOLD_LOW: begin
              if (hold_done) begin
                step_cnt   <= '0;
                cycle_done <= 1'b1;
                state      <= RAMP_UP;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: table of fade configs with expected duty
// change sequences checked through a scoreboard, plus corner sequences.
module tb_pwm_fade_ctrl;

  localparam int R   = 8;
  localparam int GAP = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         period_tick;
  logic         start;
  logic         stop;
  logic [R-1:0] min_duty;
  logic [R-1:0] max_duty;
  logic [R-1:0] step;
  logic [7:0]   periods_per_step;
  logic [7:0]   hold_periods;
  logic [R-1:0] duty;
  logic         busy;
  logic [2:0]   phase;
  logic         cycle_done;

  pwm_fade_ctrl #(.R(R)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .period_tick(period_tick),
    .start(start),
    .stop(stop),
    .min_duty(min_duty),
    .max_duty(max_duty),
    .step(step),
    .periods_per_step(periods_per_step),
    .hold_periods(hold_periods),
    .duty(duty),
    .busy(busy),
    .phase(phase),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] st;
    logic [7:0] pps;
    logic [7:0] hold;
    int         nticks;
    int         ncd;
    int         nexp;
    int         exp[12];
  } vec_t;

  vec_t vecs[4];
  int   sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cd_cnt = 0;
  int   last_duty = 0;
  logic tick_s;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Every duty change must land on a tick and match the next queued value.
  always @(posedge clk) begin
    tick_s = period_tick;
    #1;
    if (!reset_n) begin
      last_duty = int'(duty);
    end else begin
      if (cycle_done) begin
        cd_cnt++;
        chk("cycle_done_on_tick", int'(tick_s), 1);
      end
      if (int'(duty) != last_duty) begin
        chk("duty_change_on_tick", int'(tick_s), 1);
        if (sb.size() == 0) begin
          chk("unexpected_duty_change", int'(duty), last_duty);
        end else begin
          chk("duty_seq", int'(duty), sb.pop_front());
        end
        last_duty = int'(duty);
      end
    end
  end

  task automatic do_tick();
    repeat (GAP - 1) @(negedge clk);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] mn, input logic [7:0] mx,
                          input logic [7:0] st, input logic [7:0] pps,
                          input logic [7:0] hold);
    min_duty         = mn;
    max_duty         = mx;
    step             = st;
    periods_per_step = pps;
    hold_periods     = hold;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("phase_load", int'(phase), 1);
  endtask

  // Stop pulse ~3 clocks ahead of a tick; duty must hold until the tick.
  task automatic do_stop(input int hold_duty);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("duty_held_until_tick", int'(duty), hold_duty);
    chk("busy_before_stop_tick", int'(busy), 1);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    chk("duty_after_stop", int'(duty), 0);
    chk("phase_after_stop", int'(phase), 0);
    chk("busy_after_stop", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{mn: 8'd10, mx: 8'd50, st: 8'd10, pps: 8'd2, hold: 8'd1,
                nticks: 24, ncd: 1, nexp: 11,
                exp: '{10, 20, 30, 40, 50, 40, 30, 20, 10, 20, 0, 0}};
    vecs[1] = '{mn: 8'd0, mx: 8'd255, st: 8'd100, pps: 8'd1, hold: 8'd0,
                nticks: 10, ncd: 1, nexp: 8,
                exp: '{100, 200, 255, 155, 55, 0, 100, 0, 0, 0, 0, 0}};
    vecs[2] = '{mn: 8'd5, mx: 8'd8, st: 8'd0, pps: 8'd0, hold: 8'd0,
                nticks: 10, ncd: 1, nexp: 9,
                exp: '{5, 6, 7, 8, 7, 6, 5, 6, 0, 0, 0, 0}};
    vecs[3] = '{mn: 8'd60, mx: 8'd20, st: 8'd1, pps: 8'd1, hold: 8'd0,
                nticks: 6, ncd: 1, nexp: 5,
                exp: '{60, 20, 60, 20, 0, 0, 0, 0, 0, 0, 0, 0}};

    reset_n = 1'b0;
    period_tick = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    min_duty = '0;
    max_duty = '0;
    step = '0;
    periods_per_step = '0;
    hold_periods = '0;
    repeat (3) @(negedge clk);
    chk("reset_duty", int'(duty), 0);
    chk("reset_phase", int'(phase), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cycle_done", int'(cycle_done), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Simultaneous start+stop in IDLE, then a tick: must remain IDLE.
    min_duty = 8'd33;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    do_tick();
    chk("start_stop_idle_phase", int'(phase), 0);
    chk("start_stop_idle_duty", int'(duty), 0);

    for (int i = 0; i < 4; i++) begin
      cd_cnt = 0;
      for (int k = 0; k < vecs[i].nexp; k++) sb.push_back(vecs[i].exp[k]);
      do_start(vecs[i].mn, vecs[i].mx, vecs[i].st, vecs[i].pps, vecs[i].hold);
      repeat (vecs[i].nticks) do_tick();
      do_stop(vecs[i].exp[vecs[i].nexp - 2]);
      chk("cycle_done_count", cd_cnt, vecs[i].ncd);
      chk("scoreboard_drained", sb.size(), 0);
    end

    // Stop during HOLD_HIGH.
    sb = '{10, 20, 30, 40, 50, 0};
    do_start(8'd10, 8'd50, 8'd10, 8'd2, 8'd1);
    repeat (9) do_tick();
    chk("hold_high_phase", int'(phase), 3);
    do_stop(50);
    chk("hold_high_sb_drained", sb.size(), 0);

    // max_duty changed and start re-pulsed mid-sequence: both ignored.
    sb = '{10, 20, 30, 40, 50, 0};
    do_start(8'd10, 8'd50, 8'd10, 8'd1, 8'd0);
    max_duty = 8'd30;
    do_tick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) do_tick();
    chk("latched_max_duty", int'(duty), 50);
    chk("latched_max_phase", int'(phase), 3);
    do_stop(50);
    chk("latched_sb_drained", sb.size(), 0);

    // Asynchronous reset while ramping up at duty 40.
    sb = '{10, 20, 30, 40};
    do_start(8'd10, 8'd50, 8'd10, 8'd1, 8'd0);
    repeat (4) do_tick();
    chk("pre_reset_phase", int'(phase), 2);
    chk("pre_reset_duty", int'(duty), 40);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_duty", int'(duty), 0);
    chk("async_reset_phase", int'(phase), 0);
    chk("async_reset_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) do_tick();
    chk("post_reset_idle", int'(phase), 0);
    chk("reset_sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter R, default 8: PWM resolution; width of all duty-related buses.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port period_tick  input  1: one-cycle pulse when the driven PWM counter wraps; the only instant duty may change.
REQ-005 SHALL have port start  input  1: level sampled each cycle; requests a fade sequence.
REQ-006 SHALL have port stop  input  1: level sampled each cycle; requests abort to dark.
REQ-007 SHALL have port min_duty  input  R: low plateau duty.
REQ-008 SHALL have port max_duty  input  R: high plateau duty.
REQ-009 SHALL have port step  input  R: duty increment/decrement per ramp step; 0 treated as 1.
REQ-010 SHALL have port periods_per_step  input  8: PWM periods per ramp step; 0 treated as 1.
REQ-011 SHALL have port hold_periods  input  8: plateau length; plateau lasts hold_periods+1 periods.
REQ-012 SHALL have port duty  output  R: registered duty to the PWM generator.
REQ-013 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-014 SHALL have port phase  output  3: state code IDLE=0, LOAD=1, RAMP_UP=2, HOLD_HIGH=3, RAMP_DOWN=4, HOLD_LOW=5.
REQ-015 SHALL have port cycle_done  output  1: one-cycle pulse on each HOLD_LOW->RAMP_UP transition.

Function
REQ-016 SHALL latch min_duty, max_duty, step, periods_per_step, hold_periods into internal registers on start acceptance; later input changes have no effect until next start.
REQ-017 SHALL accept start only in IDLE with stop=0: next state LOAD, duty unchanged.
REQ-018 SHALL change duty only on cycles with period_tick=1, except reset.
REQ-019 LOAD: on period_tick, duty<=min_duty, step_cnt<=0, go RAMP_UP.
REQ-020 RAMP_UP: each period_tick increments step_cnt; on tick where step_cnt==pps-1, step_cnt<=0 and duty<=duty+step computed at R+1 bits.
REQ-021 RAMP_UP: if that sum >= max_duty, duty<=max_duty, hold_cnt<=0, go HOLD_HIGH (saturating, no wrap).
REQ-022 HOLD_HIGH: each tick increments hold_cnt; on tick where hold_cnt==hold_periods, go RAMP_DOWN, step_cnt<=0.
REQ-023 RAMP_DOWN: step timing as REQ-020; duty<=duty-step at R+1 bits signed; if result <= min_duty (incl. underflow), duty<=min_duty, hold_cnt<=0, go HOLD_LOW.
REQ-024 HOLD_LOW: as REQ-022; on exit go RAMP_UP, step_cnt<=0, assert cycle_done for that cycle; sequence loops until stop.
REQ-025 min_duty >= max_duty: first RAMP_UP step yields max_duty, first RAMP_DOWN step yields min_duty; alternation is the required behaviour.
REQ-026 stop=1 in any non-IDLE state sets stop_pending; on next period_tick (including same cycle) duty<=0, counters cleared, go IDLE.
REQ-027 stop has priority over start and over any same-tick state transition; start while busy is ignored.
REQ-028 stop in IDLE has no effect; duty holds its value.
REQ-029 busy and phase SHALL be derived from the state register (registered outputs, no combinational input paths).

Reset
REQ-030 reset_n low asynchronously forces state IDLE, duty=0, busy=0, phase=0, cycle_done=0, all counters and stop_pending 0, config registers 0.
REQ-031 Reset asserted mid-sequence SHALL abort immediately; after release the block waits in IDLE for start.

Verification
REQ-032 Reset mid-RAMP_UP with duty=40 -> duty=0, phase=0, busy=0 same cycle as reset_n falls.
REQ-033 min=10, max=50, step=10, pps=2, hold=1, tick every 256 clk, pulse start -> duty 10,20,30,40,50 changing every 2nd tick; HOLD_HIGH spans 2 ticks; ramps down to 10; cycle_done pulses once after HOLD_LOW.
REQ-034 min=0, max=255, step=100 -> up sequence 0,100,200,255 (no wrap); down sequence 155,55,0 (no underflow).
REQ-035 stop asserted 3 clk before a tick during HOLD_HIGH -> duty stays 50 until tick, then duty=0, phase=0; simultaneous start+stop in IDLE -> stays IDLE.
REQ-036 step=0, pps=0 -> treated as 1: duty changes by 1 on every tick.
REQ-037 Change max_duty input mid-sequence -> no effect on plateau value until next start.
